mux_arb_nto1: RTL and testbench
===============================

Name: mux_arb_nto1

Overview:
Parametrised N-channel, W-bit registered multiplexer. It is the successor to our combinational 32-bit 2:1 mux. Each input channel has a valid/ready handshake. One channel is granted per cycle, chosen by explicit select, fixed priority or round-robin. The granted word is captured in a single-entry output register with its own valid/ready handshake. It sits between multiple datapath producers (register-file ports, ALU and memory results) and a single shared consumer such as the writeback bus.

Parameters:
WIDTH, 32, data width of every channel in bits
NCH, 4, number of input channels (2..16)
SELW, $clog2(NCH), width of sel and out_ch (derived; not overridden)

Ports:
clk        input   1            rising-edge clock
reset      input   1            synchronous, active-high reset
mode       input   2            0=explicit sel, 1=fixed priority, 2=round-robin, 3=treated as 1
sel        input   SELW         channel index used when mode=0
in_data    input   NCH*WIDTH    channel i occupies bits [i*WIDTH +: WIDTH]
in_valid   input   NCH          per-channel valid
in_ready   output  NCH          per-channel ready (combinational)
out_data   output  WIDTH        registered selected word
out_ch     output  SELW         index of the channel that produced out_data
out_valid  output  1            output register holds a word
out_ready  input   1            consumer accepts the word

Behaviour:
- Reset (sync, active-high): out_valid=0, out_data=0, out_ch=0, rr_ptr=0. in_ready is 0 during the reset cycle. Reset mid-transfer discards the held word; no input transfer completes in that cycle.
- can_accept = !out_valid | out_ready.
- Grant vector (combinational, at most one bit set):
  - mode 0: grant[sel] = in_valid[sel]. A sel value >= NCH grants nothing.
  - mode 1/3: lowest-index valid channel wins.
  - mode 2: first valid channel searching from rr_ptr upward, wrapping NCH-1 -> 0.
- in_ready[i] = grant[i] & can_accept & !reset. Channel i transfers when in_valid[i] & in_ready[i].
- On a transfer: out_data <= that channel's word, out_ch <= i, out_valid <= 1, at the next clk edge. Latency is 1 cycle.
- On out_valid & out_ready with no new transfer: out_valid <= 0. out_data and out_ch hold their last value.
- Simultaneous drain and capture: the new word replaces the old one in the same edge and out_valid stays 1. Sustained throughput is 1 word/cycle.
- Stall (out_valid & !out_ready): out_data and out_ch are stable and all in_ready bits are 0.
- rr_ptr changes only on a transfer in mode 2: rr_ptr <= (i == NCH-1) ? 0 : i+1. It holds in all other modes and cycles.
- Mode or sel changes affect only the next grant decision, never the word already held.
- Producers must hold in_data and in_valid until ready. The block does not check this.
- No arithmetic beyond index compare and increment modulo NCH. NCH need not be a power of two.

Decomposition:
- Package mux_arb_pkg: mode constants MODE_SEL=2'd0, MODE_PRIO=2'd1, MODE_RR=2'd2.
- Sub-module rr_arbiter (parameter NCH): inputs req[NCH], ptr[SELW], mode, sel. Outputs one-hot grant[NCH] and encoded grant_idx[SELW]. It is purely combinational.
- The top level holds the output register, rr_ptr, the can_accept logic and the data mux (AND-OR over the one-hot grant, in the style of the gate-level 2:1 mux).

Test Plan:
- Reset/basic: assert reset with all inputs valid -> out_valid=0, out_data=0, in_ready=0. Release reset with mode=0, sel=2, in_data ch2=32'hDEADBEEF, out_ready=1 -> next cycle out_valid=1, out_data=32'hDEADBEEF, out_ch=2.
- Fixed priority: mode=1, in_valid=4'b1010, out_ready=1 -> ch1 granted every cycle while valid. When ch1 valid drops, ch3 granted the following cycle.
- Round-robin fairness: mode=2, in_valid=4'b1111 held, out_ready=1 -> out_ch sequence 0,1,2,3,0,1 on consecutive cycles. With in_valid=4'b1001 the sequence is 0,3,0,3.
- Back-pressure: out_ready=0 for 3 cycles with a word 32'h0000_1234 held -> out_data and out_ch stable and in_ready=0. Restore out_ready=1 -> next word is captured the same edge; no cycle gap and no duplicate.
- Explicit sel edge cases: mode=0, sel=1 with in_valid[1]=0 and in_valid[0]=1 -> no grant and out_valid stays 0. Build with NCH=3 and sel=3 -> no grant.
- Reset mid-stall: out_valid=1 and out_ready=0, assert reset one cycle -> out_valid=0 and rr_ptr=0. The first round-robin grant after reset goes to ch0.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// -----------------------------------------------------------------------------
// mux_arb_pkg
// Shared definitions for the N-to-1 registered arbitrating multiplexer.
//   MODE_SEL  : explicit channel select via sel
//   MODE_PRIO : fixed priority, lowest index wins (mode 3 aliases to this)
//   MODE_RR   : round-robin starting at the rotating pointer
// -----------------------------------------------------------------------------
package mux_arb_pkg;

    localparam logic [1:0] MODE_SEL  = 2'd0;
    localparam logic [1:0] MODE_PRIO = 2'd1;
    localparam logic [1:0] MODE_RR   = 2'd2;

endpackage : mux_arb_pkg

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational grant logic for mux_arb_nto1. Produces a one-hot
// grant (at most one bit set) and its encoded index.
//
// Ports:
//   req       in   NCH   per-channel request (producer valid)
//   ptr       in   SELW  round-robin start index (always < NCH)
//   mode      in   2     arbitration mode (see mux_arb_pkg)
//   sel       in   SELW  explicit channel index for MODE_SEL
//   grant     out  NCH   one-hot grant, all-zero when nothing is granted
//   grant_idx out  SELW  index of the granted channel (0 when none)
// -----------------------------------------------------------------------------
module rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter  int NCH  = 4,
    localparam int SELW = $clog2(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    input  logic [1:0]      mode,
    input  logic [SELW-1:0] sel,
    output logic [NCH-1:0]  grant,
    output logic [SELW-1:0] grant_idx
);

    always_comb begin : p_grant
        int  w_idx;
        logic w_found;
        grant   = '0;
        w_idx   = 0;
        w_found = 1'b0;
        case (mode)
            MODE_SEL: begin
                // A sel value with no matching channel (sel >= NCH when NCH
                // is not a power of two) simply matches no iteration.
                for (int i = 0; i < NCH; i++) begin
                    if (sel == SELW'(i) && req[i]) begin
                        grant[i] = 1'b1;
                    end
                end
            end
            MODE_RR: begin
                // Search upward from ptr, wrapping NCH-1 -> 0. ptr is kept
                // below NCH by the top level, so one subtract is enough.
                for (int k = 0; k < NCH; k++) begin
                    w_idx = int'(ptr) + k;
                    if (w_idx >= NCH) begin
                        w_idx = w_idx - NCH;
                    end
                    if (!w_found && req[w_idx]) begin
                        grant[w_idx] = 1'b1;
                        w_found      = 1'b1;
                    end
                end
            end
            default: begin
                // MODE_PRIO and the reserved encoding: lowest index wins.
                for (int i = 0; i < NCH; i++) begin
                    if (!w_found && req[i]) begin
                        grant[i] = 1'b1;
                        w_found  = 1'b1;
                    end
                end
            end
        endcase
    end

    always_comb begin : p_encode
        grant_idx = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant[i]) begin
                grant_idx = SELW'(i);
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/mux_arb_nto1.sv
// -----------------------------------------------------------------------------
// mux_arb_nto1
// N-channel, WIDTH-bit arbitrating multiplexer with a single-entry registered
// output. One channel is granted per cycle (explicit select, fixed priority
// or round-robin); the granted word lands in the output register one cycle
// later. Drain and capture on the same edge give 1 word/cycle throughput.
//
// Ports:
//   clk        in   1           rising-edge clock
//   reset      in   1           synchronous active-high reset
//   mode       in   2           0=sel, 1=priority, 2=round-robin, 3=priority
//   sel        in   SELW        channel index for mode 0
//   in_data    in   NCH*WIDTH   channel i at [i*WIDTH +: WIDTH]
//   in_valid   in   NCH         per-channel valid
//   in_ready   out  NCH         per-channel ready (combinational)
//   out_data   out  WIDTH       registered selected word
//   out_ch     out  SELW        channel that produced out_data
//   out_valid  out  1           output register holds a word
//   out_ready  in   1           consumer accepts the word
// -----------------------------------------------------------------------------
module mux_arb_nto1
    import mux_arb_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int NCH   = 4,
    localparam int SELW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           mode,
    input  logic [SELW-1:0]      sel,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_ch,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic [WIDTH-1:0] r_out_data;
    logic [SELW-1:0]  r_out_ch;
    logic             r_out_valid;
    logic [SELW-1:0]  r_rr_ptr;

    logic [NCH-1:0]   w_grant;
    logic [SELW-1:0]  w_grant_idx;
    logic             w_can_accept;
    logic             w_xfer;
    logic [WIDTH-1:0] w_mux_data;
    logic [SELW-1:0]  w_ptr_next;

    rr_arbiter #(
        .NCH (NCH)
    ) u_arb (
        .req       (in_valid),
        .ptr       (r_rr_ptr),
        .mode      (mode),
        .sel       (sel),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    // The register can take a new word when empty or when its current word
    // leaves on this same edge.
    assign w_can_accept = !r_out_valid || out_ready;

    // Grant already implies valid; masking by reset keeps any transfer from
    // completing in a reset cycle.
    assign in_ready = w_grant & {NCH{w_can_accept && !reset}};
    assign w_xfer   = |(in_valid & in_ready);

    // AND-OR data mux over the one-hot grant.
    always_comb begin : p_mux
        w_mux_data = '0;
        for (int i = 0; i < NCH; i++) begin
            w_mux_data = w_mux_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{w_grant[i]}});
        end
    end

    // Pointer moves to the channel after the winner so it gets lowest
    // precedence next time.
    assign w_ptr_next = (w_grant_idx == SELW'(NCH - 1)) ? '0 : w_grant_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_rr_ptr    <= '0;
        end else begin
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_mux_data;
                r_out_ch    <= w_grant_idx;
                if (mode == MODE_RR) begin
                    r_rr_ptr <= w_ptr_next;
                end
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign out_valid = r_out_valid;

endmodule : mux_arb_nto1

// File: tb/tb_mux_arb_nto1.sv
module tb_mux_arb_nto1;

    typedef struct packed {
        logic [1:0]  ch;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  mode;
    logic [1:0]  sel;
    logic [31:0] d [4];
    logic [127:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [31:0] out_data;
    logic [1:0]  out_ch;
    logic        out_valid;
    logic        out_ready;

    // Second build with NCH=3 for the out-of-range select and odd wrap.
    logic [1:0]  mode3;
    logic [1:0]  sel3;
    logic [23:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic [7:0]  out_data3;
    logic [1:0]  out_ch3;
    logic        out_valid3;
    logic        out_ready3;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    assign in_data  = {d[3], d[2], d[1], d[0]};
    assign in_data3 = {8'hC2, 8'hC1, 8'hC0};

    mux_arb_nto1 #(.WIDTH(32), .NCH(4)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    mux_arb_nto1 #(.WIDTH(8), .NCH(3)) u_dut3 (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode3),
        .sel       (sel3),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .out_data  (out_data3),
        .out_ch    (out_ch3),
        .out_valid (out_valid3),
        .out_ready (out_ready3)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] ch, input logic [31:0] data);
        exp_t e;
        e.ch   = ch;
        e.data = data;
        sb.push_back(e);
    endtask

    // One clock: the consumer takes the held word at the negedge when it
    // will be accepted, then inputs may change 1 time unit past posedge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_word", {30'd0, out_ch, out_data}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("sb_ch", 64'(out_ch), 64'(e.ch));
                chk("sb_data", 64'(out_data), 64'(e.data));
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---- reset with everything valid
        reset = 1'b1; mode = 2'd0; sel = 2'd0; out_ready = 1'b1;
        in_valid = 4'b1111;
        d[0] = 32'h1000_0000; d[1] = 32'h1000_0001; d[2] = 32'h1000_0002; d[3] = 32'h1000_0003;
        mode3 = 2'd0; sel3 = 2'd0; in_valid3 = 3'b000; out_ready3 = 1'b1;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'h0);
        tick();
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_out_data", 64'(out_data), 64'h0);
        chk("rst_out_ch", 64'(out_ch), 64'h0);
        chk("rst_in_ready2", 64'(in_ready), 64'h0);
        chk("rst3_out_valid", 64'(out_valid3), 64'h0);

        // ---- explicit sel, first word
        reset = 1'b0; mode = 2'd0; sel = 2'd2; d[2] = 32'hDEADBEEF;
        #1;
        chk("sel_in_ready", 64'(in_ready), 64'h4);
        push(2'd2, 32'hDEADBEEF);
        tick();
        chk("sel_out_valid", 64'(out_valid), 64'h1);
        chk("sel_out_data", 64'(out_data), 64'hDEADBEEF);
        chk("sel_out_ch", 64'(out_ch), 64'h2);
        in_valid = 4'b0000;
        tick();
        chk("sel_drained", 64'(out_valid), 64'h0);

        // ---- fixed priority: ch1 beats ch3 while valid
        mode = 2'd1; in_valid = 4'b1010; d[3] = 32'hA300_0000;
        #1;
        chk("prio_in_ready", 64'(in_ready), 64'h2);
        for (int k = 0; k < 3; k++) begin
            d[1] = 32'hA100_0000 + k;
            push(2'd1, 32'hA100_0000 + k);
            tick();
        end
        in_valid = 4'b1000;
        push(2'd3, 32'hA300_0000);
        tick();
        chk("prio_ch3_out_ch", 64'(out_ch), 64'h3);
        // reserved mode encoding behaves as priority
        mode = 2'd3; in_valid = 4'b0110; d[1] = 32'hA1A1_A1A1;
        #1;
        chk("mode3_in_ready", 64'(in_ready), 64'h2);
        push(2'd1, 32'hA1A1_A1A1);
        tick();
        in_valid = 4'b0000;
        tick();

        // ---- round-robin, all valid: 0,1,2,3,0,1,2,3 then 0,3,0,3
        mode = 2'd2; in_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            d[k % 4] = 32'hB000_0000 + k;
            push(2'(k % 4), 32'hB000_0000 + k);
            tick();
        end
        in_valid = 4'b1001;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) begin
                d[0] = 32'hB100_0000 + k;
                push(2'd0, 32'hB100_0000 + k);
            end else begin
                d[3] = 32'hB100_0000 + k;
                push(2'd3, 32'hB100_0000 + k);
            end
            tick();
        end
        in_valid = 4'b0000;
        tick();

        // ---- back-pressure
        mode = 2'd1; in_valid = 4'b0001; d[0] = 32'h0000_1234;
        push(2'd0, 32'h0000_1234);
        tick();
        out_ready = 1'b0; d[0] = 32'h0000_5678;
        #1;
        chk("bp_in_ready0", 64'(in_ready), 64'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_hold_data", 64'(out_data), 64'h0000_1234);
            chk("bp_hold_ch", 64'(out_ch), 64'h0);
            chk("bp_in_ready", 64'(in_ready), 64'h0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(in_ready), 64'h1);
        push(2'd0, 32'h0000_5678);
        tick();
        chk("bp_next_valid", 64'(out_valid), 64'h1);
        chk("bp_next_data", 64'(out_data), 64'h0000_5678);
        in_valid = 4'b0000;
        tick();
        chk("bp_no_dup", 64'(out_valid), 64'h0);
        tick();

        // ---- explicit sel with the selected channel idle
        mode = 2'd0; sel = 2'd1; in_valid = 4'b0001;
        #1;
        chk("selidle_in_ready", 64'(in_ready), 64'h0);
        tick();
        chk("selidle_out_valid", 64'(out_valid), 64'h0);
        in_valid = 4'b0000;

        // ---- NCH=3 build: sel=3 grants nothing, then sel=2, then RR wrap
        mode3 = 2'd0; sel3 = 2'd3; in_valid3 = 3'b111;
        #1;
        chk("n3_sel3_in_ready", 64'(in_ready3), 64'h0);
        tick();
        chk("n3_sel3_out_valid", 64'(out_valid3), 64'h0);
        sel3 = 2'd2;
        #1;
        chk("n3_sel2_in_ready", 64'(in_ready3), 64'h4);
        tick();
        chk("n3_sel2_out_ch", 64'(out_ch3), 64'h2);
        chk("n3_sel2_out_data", 64'(out_data3), 64'hC2);
        mode3 = 2'd2;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("n3_rr_out_ch", 64'(out_ch3), 64'(k % 3));
        end
        in_valid3 = 3'b000;

        // ---- reset while stalled; pointer returns to 0
        mode = 2'd2; in_valid = 4'b0010; d[1] = 32'hC0FF_EE01;
        push(2'd1, 32'hC0FF_EE01);
        tick();
        out_ready = 1'b0; in_valid = 4'b0000;
        tick();
        chk("rs_stalled_valid", 64'(out_valid), 64'h1);
        reset = 1'b1;
        void'(sb.pop_back());   // the held word is discarded by reset
        tick();
        reset = 1'b0;
        chk("rs_out_valid", 64'(out_valid), 64'h0);
        chk("rs_out_data", 64'(out_data), 64'h0);
        out_ready = 1'b1; in_valid = 4'b1111;
        d[0] = 32'hE000_0000; d[1] = 32'hE000_0001; d[2] = 32'hE000_0002; d[3] = 32'hE000_0003;
        #1;
        chk("rs_rr_first_ready", 64'(in_ready), 64'h1);
        push(2'd0, 32'hE000_0000);
        tick();
        chk("rs_rr_first_ch", 64'(out_ch), 64'h0);
        in_valid = 4'b0000;
        tick();
        tick();

        chk("sb_empty", 64'(sb.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_mux_arb_nto1
